// File: rtl/cbfp_pkg.sv
// Shared types and helpers for the CBFP block-exponent datapath.
// Holds the default widths, the count type, an unsigned min helper and an
// elaboration-time configuration check.
package cbfp_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 25;
    localparam int unsigned DEF_MAG_WIDTH  = 5;
    // Widest count the min helper handles; narrower counts are zero-extended.
    localparam int unsigned MAG_MAX_W      = 8;

    typedef logic [DEF_MAG_WIDTH-1:0] mag_t;
    typedef logic [MAG_MAX_W-1:0]     mag_wide_t;

    // Unsigned minimum of two redundant-sign counts.
    function automatic mag_wide_t min_mag(input mag_wide_t a, input mag_wide_t b);
        return (a < b) ? a : b;
    endfunction

    // True when a MAG_WIDTH-bit count can hold every value 0..DATA_WIDTH-1.
    function automatic bit mag_width_ok(input int unsigned dw, input int unsigned mw);
        return (mw <= MAG_MAX_W) && ((64'(1) << mw) > 64'(dw - 1));
    endfunction

endpackage

// File: rtl/cbfp_lsc.sv
// Combinational redundant-sign counter.
// Ports:
//   x     : signed sample, DATA_WIDTH bits
//   cnt_c : number of bits directly below the sign that equal the sign
//           (0..DATA_WIDTH-1), unregistered
module cbfp_lsc
    import cbfp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MAG_WIDTH  = DEF_MAG_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [MAG_WIDTH-1:0]  cnt_c
);

    // Bits below the sign that differ from it; the highest one ends the run.
    logic [DATA_WIDTH-2:0] diff;

    assign diff = x[DATA_WIDTH-2:0] ^ {(DATA_WIDTH-1){x[DATA_WIDTH-1]}};

    // Priority encoder: ascending scan so the highest differing bit wins.
    always_comb begin
        cnt_c = MAG_WIDTH'(DATA_WIDTH - 1);
        for (int i = 0; i < int'(DATA_WIDTH) - 1; i++) begin
            if (diff[i]) begin
                cnt_c = MAG_WIDTH'(int'(DATA_WIDTH) - 2 - i);
            end
        end
    end

endmodule

// File: rtl/cbfp_blk_exp_detect.sv
// Pipelined block-exponent detector for the CBFP FFT stages.
// S1 registers per-part redundant-sign counts, S2 the per-beat minimum,
// S3 accumulates the minimum over BLK_BEATS valid beats and emits it.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : abort the current block and drop in-flight beats
//   in_valid   : din_re/din_im carry a beat this cycle
//   din_re/im  : LANES signed parts of DATA_WIDTH bits each
//   exp_valid  : one-cycle pulse, exp_out updated
//   exp_out    : block minimum redundant-sign count, held between blocks
//   blk_busy   : at least one beat of the current block accumulated
module cbfp_blk_exp_detect
    import cbfp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LANES      = 8,
    parameter int unsigned BLK_BEATS  = 2,
    parameter int unsigned MAG_WIDTH  = DEF_MAG_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear,
    input  logic                             in_valid,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] din_re,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] din_im,
    output logic                             exp_valid,
    output logic [MAG_WIDTH-1:0]             exp_out,
    output logic                             blk_busy
);

    localparam int unsigned NPARTS = 2 * LANES;
    localparam int unsigned CNT_W  = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_BEATS - 1);

    if (!mag_width_ok(DATA_WIDTH, MAG_WIDTH) || DATA_WIDTH < 4 || BLK_BEATS < 1 ||
        LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_bad_cfg
        $error("cbfp_blk_exp_detect: illegal DATA_WIDTH/MAG_WIDTH/LANES/BLK_BEATS");
    end

    function automatic logic [MAG_WIDTH-1:0] mn(input logic [MAG_WIDTH-1:0] a,
                                                input logic [MAG_WIDTH-1:0] b);
        return MAG_WIDTH'(min_mag(MAG_MAX_W'(a), MAG_MAX_W'(b)));
    endfunction

    // Per-part counters; real parts at even indices, imaginary at odd.
    logic [MAG_WIDTH-1:0] cnt_c [NPARTS];

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        cbfp_lsc #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) u_lsc_re (
            .x     (din_re[g]),
            .cnt_c (cnt_c[2*g])
        );
        cbfp_lsc #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) u_lsc_im (
            .x     (din_im[g]),
            .cnt_c (cnt_c[2*g+1])
        );
    end

    // S1: count registers.
    logic                 s1_valid;
    logic [MAG_WIDTH-1:0] s1_cnt [NPARTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            for (int i = 0; i < int'(NPARTS); i++) s1_cnt[i] <= '0;
        end else begin
            s1_valid <= in_valid & ~clear;
            if (in_valid) s1_cnt <= cnt_c;
        end
    end

    // Balanced min tree stored as a heap: leaves at NPARTS-1.., root at 0.
    logic [MAG_WIDTH-1:0] tree [2*NPARTS-1];

    always_comb begin
        for (int i = 0; i < int'(NPARTS); i++) tree[int'(NPARTS) - 1 + i] = s1_cnt[i];
        for (int i = int'(NPARTS) - 2; i >= 0; i--) tree[i] = mn(tree[2*i+1], tree[2*i+2]);
    end

    // S2: beat minimum.
    logic                 s2_valid;
    logic [MAG_WIDTH-1:0] s2_min;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_min   <= '0;
        end else begin
            s2_valid <= s1_valid & ~clear;
            if (s1_valid) s2_min <= tree[0];
        end
    end

    // S3: block accumulator and output register.
    logic [MAG_WIDTH-1:0] run_min, nxt_run_min;
    logic [CNT_W-1:0]     beat_cnt, nxt_beat_cnt;
    logic [MAG_WIDTH-1:0] nxt_exp_out;
    logic                 nxt_exp_valid;
    logic                 nxt_blk_busy;

    always_comb begin
        nxt_run_min   = run_min;
        nxt_beat_cnt  = beat_cnt;
        nxt_exp_out   = exp_out;
        nxt_exp_valid = 1'b0;
        if (clear) begin
            nxt_beat_cnt = '0;
        end else if (s2_valid) begin
            if (beat_cnt == LAST_CNT) begin
                nxt_exp_out   = (BLK_BEATS == 1) ? s2_min : mn(run_min, s2_min);
                nxt_exp_valid = 1'b1;
                nxt_beat_cnt  = '0;
            end else begin
                nxt_run_min  = (beat_cnt == '0) ? s2_min : mn(run_min, s2_min);
                nxt_beat_cnt = beat_cnt + CNT_W'(1);
            end
        end
        nxt_blk_busy = (nxt_beat_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_min   <= '0;
            beat_cnt  <= '0;
            exp_out   <= '0;
            exp_valid <= 1'b0;
            blk_busy  <= 1'b0;
        end else begin
            run_min   <= nxt_run_min;
            beat_cnt  <= nxt_beat_cnt;
            exp_out   <= nxt_exp_out;
            exp_valid <= nxt_exp_valid;
            blk_busy  <= nxt_blk_busy;
        end
    end

endmodule

// File: tb/tb_cbfp_blk_exp_detect.sv
// Scoreboard bench for cbfp_blk_exp_detect: two configurations side by side,
// directed and random beats, gaps, clear and reset.
module tb_cbfp_blk_exp_detect;

    localparam int DWA = 25, LNA = 8, BBA = 2, MWA = 5;
    localparam int DWB = 16, LNB = 4, BBB = 3, MWB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                      clear_a = 1'b0, in_valid_a = 1'b0;
    logic [LNA-1:0][DWA-1:0]   din_re_a = '0, din_im_a = '0;
    logic                      exp_valid_a, blk_busy_a;
    logic [MWA-1:0]            exp_out_a;

    logic                      clear_b = 1'b0, in_valid_b = 1'b0;
    logic [LNB-1:0][DWB-1:0]   din_re_b = '0, din_im_b = '0;
    logic                      exp_valid_b, blk_busy_b;
    logic [MWB-1:0]            exp_out_b;

    cbfp_blk_exp_detect #(.DATA_WIDTH(DWA), .LANES(LNA), .BLK_BEATS(BBA), .MAG_WIDTH(MWA)) dut_a (
        .clk(clk), .rst(rst), .clear(clear_a), .in_valid(in_valid_a),
        .din_re(din_re_a), .din_im(din_im_a),
        .exp_valid(exp_valid_a), .exp_out(exp_out_a), .blk_busy(blk_busy_a)
    );

    cbfp_blk_exp_detect #(.DATA_WIDTH(DWB), .LANES(LNB), .BLK_BEATS(BBB), .MAG_WIDTH(MWB)) dut_b (
        .clk(clk), .rst(rst), .clear(clear_b), .in_valid(in_valid_b),
        .din_re(din_re_b), .din_im(din_im_b),
        .exp_valid(exp_valid_b), .exp_out(exp_out_b), .blk_busy(blk_busy_b)
    );

    typedef struct { int due; int val; } ev_t;

    ev_t expq  [2][$];
    ev_t busyq [2][$];
    int  pos [2], bmin [2], cur_busy [2], last_exp [2];
    int  checks = 0, errors = 0;
    int  cyc = 0;
    bit  rst_seen = 1'b0;
    int  re_v [8], im_v [8];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Count from the value range: largest k with -2^(dw-1-k) <= v < 2^(dw-1-k).
    function automatic int ref_cnt(input longint v, input int dw);
        for (int k = dw - 1; k >= 0; k--) begin
            longint lim;
            lim = longint'(1) << (dw - 1 - k);
            if (v >= -lim && v < lim) return k;
        end
        return 0;
    endfunction

    function automatic int rval(input int dw);
        int w;
        w = int'($urandom_range(1, dw));
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d at cycle %0d", name, id, act, exp, cyc);
        end
    endtask

    // Drop everything that clear/rst at cycle c prevents from appearing.
    task automatic flush(input int id, input int c);
        while (expq[id].size() > 0 && expq[id][$].due > c) void'(expq[id].pop_back());
        while (busyq[id].size() > 0 && busyq[id][$].due > c) void'(busyq[id].pop_back());
        busyq[id].push_back('{due: c + 1, val: 0});
        pos[id] = 0;
    endtask

    task automatic model_beat(input int id);
        int dw, ln, bb, m;
        dw = (id == 0) ? DWA : DWB;
        ln = (id == 0) ? LNA : LNB;
        bb = (id == 0) ? BBA : BBB;
        m  = dw - 1;
        for (int i = 0; i < ln; i++) begin
            if (ref_cnt(re_v[i], dw) < m) m = ref_cnt(re_v[i], dw);
            if (ref_cnt(im_v[i], dw) < m) m = ref_cnt(im_v[i], dw);
        end
        bmin[id] = (pos[id] == 0 || m < bmin[id]) ? m : bmin[id];
        pos[id]++;
        if (pos[id] == bb) begin
            expq[id].push_back('{due: cyc + 3, val: bmin[id]});
            pos[id] = 0;
        end
        busyq[id].push_back('{due: cyc + 3, val: (pos[id] != 0) ? 1 : 0});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input bit v, input bit clr);
        if (id == 0) begin
            for (int i = 0; i < LNA; i++) begin
                din_re_a[i] = DWA'(re_v[i]);
                din_im_a[i] = DWA'(im_v[i]);
            end
            in_valid_a = v;
            clear_a    = clr;
        end else begin
            for (int i = 0; i < LNB; i++) begin
                din_re_b[i] = DWB'(re_v[i]);
                din_im_b[i] = DWB'(im_v[i]);
            end
            in_valid_b = v;
            clear_b    = clr;
        end
        if (clr) flush(id, cyc);
        else if (v) model_beat(id);
        tick();
        in_valid_a = 1'b0; clear_a = 1'b0;
        in_valid_b = 1'b0; clear_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_all(input int val);
        for (int i = 0; i < 8; i++) begin
            re_v[i] = val;
            im_v[i] = val;
        end
    endtask

    task automatic set_rand(input int dw);
        for (int i = 0; i < 8; i++) begin
            re_v[i] = rval(dw);
            im_v[i] = rval(dw);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush(0, cyc);
        flush(1, cyc);
        tick();
        rst = 1'b0;
    endtask

    task automatic mon(input int id, input int ev, input int eo, input int bz);
        ev_t e;
        while (busyq[id].size() > 0 && busyq[id][0].due <= cyc) begin
            cur_busy[id] = busyq[id][0].val;
            void'(busyq[id].pop_front());
        end
        if (rst_seen) begin
            chk("rst_exp_valid", id, ev, 0);
            chk("rst_exp_out", id, eo, 0);
            chk("rst_blk_busy", id, bz, 0);
            last_exp[id] = 0;
        end else begin
            chk("blk_busy", id, bz, cur_busy[id]);
            if (ev != 0) begin
                if (expq[id].size() == 0) begin
                    chk("spurious_pulse", id, ev, 0);
                end else begin
                    e = expq[id].pop_front();
                    chk("pulse_cycle", id, cyc, e.due);
                    chk("exp_out", id, eo, e.val);
                    last_exp[id] = e.val;
                end
            end else begin
                if (expq[id].size() > 0 && expq[id][0].due <= cyc) begin
                    void'(expq[id].pop_front());
                    chk("missed_pulse", id, ev, 1);
                end
                chk("exp_hold", id, eo, last_exp[id]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, int'(exp_valid_a), int'(exp_out_a), int'(blk_busy_a));
        mon(1, int'(exp_valid_b), int'(exp_out_b), int'(blk_busy_b));
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; bmin[i] = 0; cur_busy[i] = 0; last_exp[i] = 0;
        end
        set_all(0);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Zero block -> 24.
        set_all(0); drive(0, 1, 0); drive(0, 1, 0); idle(5);

        // Per-lane minimum, both orders -> 15.
        set_all(0); im_v[5] = 32'h100; drive(0, 1, 0);
        set_all(0); re_v[2] = -3;      drive(0, 1, 0); idle(4);
        set_all(0); re_v[2] = -3;      drive(0, 1, 0);
        set_all(0); im_v[5] = 32'h100; drive(0, 1, 0); idle(4);

        // Extremes -> 0, 0, 24.
        set_all(0); re_v[0] = 32'h0FF_FFFF; drive(0, 1, 0); set_all(0); drive(0, 1, 0); idle(4);
        set_all(0); im_v[3] = -(1 << 24);   drive(0, 1, 0); set_all(0); drive(0, 1, 0); idle(4);
        set_all(-1); drive(0, 1, 0); drive(0, 1, 0); idle(4);

        // Abort: a beat that would force 0 is discarded, then two beats of 1 -> 23.
        set_all(0); re_v[0] = -(1 << 24); drive(0, 1, 0);
        drive(0, 1, 1); idle(4);
        set_all(1); drive(0, 1, 0); drive(0, 1, 0); idle(5);

        // Streaming six blocks back to back.
        for (int b = 0; b < 12; b++) begin set_rand(DWA); drive(0, 1, 0); end
        idle(4);

        // Reset in the middle of block 4, then stream again.
        for (int b = 0; b < 7; b++) begin set_rand(DWA); drive(0, 1, 0); end
        do_reset();
        for (int b = 0; b < 4; b++) begin set_rand(DWA); drive(0, 1, 0); end
        idle(4);

        // Random gaps and clears.
        for (int n = 0; n < 60; n++) begin
            set_rand(DWA);
            drive(0, ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        idle(5);

        // Second configuration: gapped block at relative cycles 0, 4, 9.
        set_rand(DWB); drive(1, 1, 0); idle(3);
        set_rand(DWB); drive(1, 1, 0); idle(4);
        set_rand(DWB); drive(1, 1, 0); idle(6);

        for (int b = 0; b < 18; b++) begin set_rand(DWB); drive(1, 1, 0); end
        idle(4);

        for (int b = 0; b < 10; b++) begin set_rand(DWB); drive(1, 1, 0); end
        do_reset();
        for (int n = 0; n < 60; n++) begin
            set_rand(DWB);
            drive(1, ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        idle(6);

        chk("drain", 0, expq[0].size(), 0);
        chk("drain", 1, expq[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbfp_blk_exp_detect.md
Name: cbfp_blk_exp_detect

Overview:
Pipelined block-exponent detector for the CBFP stages of the FFT datapath.
- Each valid beat carries LANES complex samples.
- For every real and imaginary part, the block counts redundant sign bits and reduces them to a per-beat minimum.
- It tracks a running minimum over BLK_BEATS beats and emits one block exponent per block.
- The downstream CBFP shifter uses that exponent to normalise the block.

Parameters:
DATA_WIDTH, 25, signed sample width per real/imag part (min 4)
LANES, 8, complex samples per beat (power of 2, >=1)
BLK_BEATS, 2, valid beats per CBFP block (>=1)
MAG_WIDTH, 5, count width; must satisfy 2**MAG_WIDTH > DATA_WIDTH-1

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
clear  in  1  abort current block, restart counting
in_valid  in  1  din_re/din_im valid this cycle
din_re  in  LANES x DATA_WIDTH signed  real parts
din_im  in  LANES x DATA_WIDTH signed  imag parts
exp_valid  out  1  one-cycle pulse, exp_out valid
exp_out  out  MAG_WIDTH  block minimum redundant-sign count
blk_busy  out  1  at least one beat of the current block accumulated

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst); no asynchronous logic.

Count definition (per part):
- Count = number of bits directly below the sign bit that equal the sign, range 0..DATA_WIDTH-1.
- DATA_WIDTH=25 examples: 0 -> 24; -1 -> 24; 1 -> 23; -2 -> 23; 0x0FFFFFF -> 0; -2^24 -> 0; 0x000100 -> 15.

Pipeline:
- S1 registers 2*LANES counts plus valid.
- S2 registers the beat minimum (balanced min tree over 2*LANES counts) plus valid.
- S3 is the accumulator/output register.

Accumulator:
- Holds run_min (MAG_WIDTH) and beat_cnt (0..BLK_BEATS-1).
- On S2 valid with beat_cnt < BLK_BEATS-1:
  - run_min <= (beat_cnt==0) ? beat_min : min(run_min, beat_min)
  - beat_cnt++
- On S2 valid with beat_cnt == BLK_BEATS-1:
  - exp_out <= min(run_min, beat_min); use beat_min alone when BLK_BEATS==1.
  - exp_valid <= 1; beat_cnt <= 0.
- exp_valid is high for exactly one cycle.
- exp_out holds its value until the next block completes.

Latency and throughput:
- Latency from the last beat of a block sampled at in_valid (cycle N) to exp_valid high: N+3.
- Full throughput: back-to-back blocks with in_valid held high produce one exp_valid every BLK_BEATS cycles, with no bubbles.
- in_valid gaps are allowed anywhere. Beats are counted only when valid; invalid cycles do not advance any state.

blk_busy:
- blk_busy = (beat_cnt != 0), registered alongside the accumulator.

clear:
- Synchronous; takes effect on the next edge.
- Zeroes the S1/S2 valid bits, beat_cnt and blk_busy, so in-flight beats are discarded.
- Does not change exp_out.
- Suppresses an exp_valid that would have been raised on that edge.
- clear and in_valid in the same cycle: clear wins and that beat is dropped. Counting restarts with the next valid beat.

rst:
- exp_valid=0, exp_out=0, blk_busy=0, beat_cnt=0, run_min=0, all pipeline valids=0.
- rst mid-block discards the partial block.
- rst has priority over clear.

Width rules:
- Counts are unsigned MAG_WIDTH; min compare is unsigned.
- Count all-sign words as DATA_WIDTH-1; never wrap.

Decomposition:
- Package cbfp_pkg:
  - default DATA_WIDTH/MAG_WIDTH constants
  - mag_t typedef (logic [MAG_WIDTH-1:0])
  - function min_mag
  - elaboration assertion helper for 2**MAG_WIDTH > DATA_WIDTH-1
- Sub-module cbfp_lsc (parametrised DATA_WIDTH, MAG_WIDTH):
  - combinational redundant-sign counter, implemented as a priority encoder on (x ^ {x[MSB],...}) below the sign.
  - Instantiated 2*LANES times in S1.
- Min tree and accumulator stay in the top module.

Test Plan:
1. Zero block: BLK_BEATS=2, all parts 0 for 2 consecutive beats -> exp_valid single pulse 3 cycles after beat 2, exp_out=24, blk_busy high 1 cycle.
2. Per-lane minimum: beat1 all 0 except din_im[5]=0x000100 (count 15); beat2 din_re[2]=-3 (count 22) -> exp_out=15. Repeat with the two beats swapped -> 15.
3. Extremes: one part 0x0FFFFFF, then -2^24, then -1 in separate blocks -> exp_out 0, 0, 24 respectively.
4. Gapped input: beats at cycles 0, 4, 9 (BLK_BEATS=3), in_valid low otherwise -> exactly one exp_valid at cycle 12; no pulse earlier.
5. Abort: beat1 accepted, then clear coincident with beat2 valid, then 2 fresh beats of value 1 -> exactly one exp_valid with exp_out=23; exp_out holds its prior value until then.
6. Streaming plus reset: continuous in_valid for 6 blocks with random data vs. reference model -> 6 pulses spaced BLK_BEATS apart. Assert rst mid-block 4 -> all outputs 0 next cycle, no stale pulse after release. Rerun with LANES=4, DATA_WIDTH=16, MAG_WIDTH=4.
